// File: rtl/mux_16b_8input.sv
// -----------------------------------------------------------------------------
// mux_16b_8input
//
// Purpose:
//   Registered 8:1 data selector. On every rising clk edge the input chosen by
//   Op is captured into the Output register, giving exactly one cycle of
//   latency and no combinational path from any input to Output. A synchronous
//   active-high reset clears Output and drops Valid; Valid rises on the first
//   edge at which reset is low and stays high until reset is asserted again.
//
// Ports:
//   clk     in   1      rising-edge clock for all state
//   reset   in   1      synchronous active-high reset (no asynchronous path)
//   A..H    in   WIDTH  data inputs, selected by Op = 3'b000 .. 3'b111
//   Op      in   3      unsigned select code; all eight codes are decoded
//   Output  out  WIDTH  registered copy of the selected input
//   Valid   out  1      Output holds a selection rather than a reset value
// -----------------------------------------------------------------------------
module mux_16b_8input #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic [2:0]       Op,
    output logic [WIDTH-1:0] Output,
    output logic             Valid
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_output;
    logic             r_valid;

    // Select the data input addressed by Op; every code maps to a real input.
    always_comb begin
        w_sel = '0;
        case (Op)
            3'b000:  w_sel = A;
            3'b001:  w_sel = B;
            3'b010:  w_sel = C;
            3'b011:  w_sel = D;
            3'b100:  w_sel = E;
            3'b101:  w_sel = F;
            3'b110:  w_sel = G;
            3'b111:  w_sel = H;
            // Unreachable for 2-state Op; X/Z on Op resolves to zero here.
            default: w_sel = '0;
        endcase
    end

    // Capture the selection each edge; reset overrides selection on any edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_output <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_output <= w_sel;
            r_valid  <= 1'b1;
        end
    end

    assign Output = r_output;
    assign Valid  = r_valid;

endmodule

// File: tb/tb_mux_16b_8input.sv
module tb_mux_16b_8input;

    typedef struct {
        logic [15:0] out;
        logic        valid;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] A, B, C, D, E, F, G, H;
    logic [2:0]  Op;
    logic [15:0] Output;
    logic        Valid;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    logic [15:0] vals [8];

    mux_16b_8input #(.WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .E      (E),
        .F      (F),
        .G      (G),
        .H      (H),
        .Op     (Op),
        .Output (Output),
        .Valid  (Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry is popped and compared after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (Output !== e.out) begin
                errors++;
                $display("FAIL %s Output: got %0d (0x%h) expected %0d (0x%h)",
                         e.name, Output, Output, e.out, e.out);
            end
            checks++;
            if (Valid !== e.valid) begin
                errors++;
                $display("FAIL %s Valid: got %b expected %b", e.name, Valid, e.valid);
            end
        end
    end

    // Queue the expectation for the coming edge, then move to the next negedge.
    task automatic expect_edge(input logic [15:0] o, input logic v, input string nm);
        exp_t e;
        e.out   = o;
        e.valid = v;
        e.name  = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Mid-cycle check that Output has not moved since the last edge.
    task automatic check_hold(input logic [15:0] o, input string nm);
        #1;
        checks++;
        if (Output !== o) begin
            errors++;
            $display("FAIL %s Output: got %0d (0x%h) expected %0d (0x%h)",
                     nm, Output, Output, o, o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        vals[0] = 16'd235;  vals[1] = 16'd2346; vals[2] = 16'd134; vals[3] = 16'd2376;
        vals[4] = 16'd768;  vals[5] = 16'd876;  vals[6] = 16'd2457; vals[7] = 16'd456;

        // Reset held for two edges with A selected.
        reset = 1'b1;
        A = 16'd235; B = 16'd0; C = 16'd0; D = 16'd0;
        E = 16'd0;   F = 16'd0; G = 16'd0; H = 16'd0;
        Op = 3'b000;
        expect_edge(16'd0, 1'b0, "reset_edge1");
        expect_edge(16'd0, 1'b0, "reset_edge2");
        reset = 1'b0;
        expect_edge(16'd235, 1'b1, "reset_release");

        // Walk Op through all eight codes, two cycles each.
        B = 16'd2346; C = 16'd134; D = 16'd2376; E = 16'd768;
        F = 16'd876;  G = 16'd2457; H = 16'd456;
        for (int i = 0; i < 8; i++) begin
            Op = 3'(i);
            expect_edge(vals[i], 1'b1, $sformatf("op%0d_first", i));
            expect_edge(vals[i], 1'b1, $sformatf("op%0d_second", i));
        end

        // Mid-stream reset with Op=111 and Output=456.
        reset = 1'b1;
        expect_edge(16'd0, 1'b0, "midstream_reset");
        reset = 1'b0;
        expect_edge(16'd456, 1'b1, "midstream_release");

        // Unselected input change must not disturb Output.
        Op = 3'b011;
        expect_edge(16'd2376, 1'b1, "op3_select");
        A = 16'hFFFF;
        expect_edge(16'd2376, 1'b1, "unselected_A_change");
        D = 16'hFFFF;
        expect_edge(16'hFFFF, 1'b1, "selected_D_change");

        // Op and selected data change together; Output holds until the edge.
        A = 16'd235;
        Op = 3'b000;
        expect_edge(16'd235, 1'b1, "back_to_A");
        Op = 3'b101;
        F = 16'h8001;
        check_hold(16'd235, "no_comb_path_after_op_change");
        B = 16'h1234; H = 16'hABCD;
        check_hold(16'd235, "hold_between_edges");
        expect_edge(16'h8001, 1'b1, "op_and_data_same_cycle");
        expect_edge(16'h8001, 1'b1, "op5_steady");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
